// File: rtl/cache_pkg.sv
// Shared types and address-geometry helpers for the 2-way cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITE_BACK,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int word_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int line_words,
                               input int sets);
    return addr_w - byte_off_w(data_w) - word_off_w(line_words) - index_w(sets);
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: tag/data storage plus reset-cleared valid and dirty flops.
// Combinational read at `index`; a fill write takes priority over a word write.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 256
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [index_w(SETS)-1:0]           index,
  output logic [tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS)-1:0] tag,
  output logic [DATA_W*LINE_WORDS-1:0]       line,
  output logic                               valid,
  output logic                               dirty,
  input  logic                               word_we,
  input  logic [word_off_w(LINE_WORDS)-1:0]  word_sel,
  input  logic [DATA_W-1:0]                  word_data,
  input  logic [DATA_W/8-1:0]                word_be,
  input  logic                               fill_we,
  input  logic [tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS)-1:0] fill_tag,
  input  logic [DATA_W*LINE_WORDS-1:0]       fill_line,
  input  logic                               clean
);

  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS);
  localparam int LINE_W = DATA_W * LINE_WORDS;
  localparam int BE_W   = DATA_W / 8;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  assign tag   = tag_mem[index];
  assign line  = data_mem[index];
  assign valid = valid_q[index];
  assign dirty = dirty_q[index];

  always_ff @(posedge clock) begin
    if (fill_we) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_line;
    end else if (word_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (word_be[b]) data_mem[index][(int'(word_sel) * BE_W + b) * 8 +: 8] <= word_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end else if (clean) begin
      dirty_q[index] <= 1'b0;
    end
  end

endmodule

// File: rtl/cache_controller_2way.sv
// 2-way set-associative write-back/write-allocate cache controller with per-set LRU.
// Memory handshake: a request transfers on a rising edge where mem_req_valid && mem_req_ready.
module cache_controller_2way
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 256
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpu_req_valid,
  input  logic                         cpu_req_rw,
  input  logic [ADDR_W-1:0]            cpu_req_addr,
  input  logic [DATA_W-1:0]            cpu_req_wdata,
  input  logic [DATA_W/8-1:0]          cpu_req_be,
  output logic                         cache_ready,
  output logic                         cpu_resp_valid,
  output logic [DATA_W-1:0]            cpu_resp_rdata,
  output logic                         mem_req_valid,
  output logic                         mem_req_rw,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [DATA_W*LINE_WORDS-1:0] mem_req_wdata,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [DATA_W*LINE_WORDS-1:0] mem_resp_rdata,
  output state_t                       state
);

  localparam int BE_W   = DATA_W / 8;
  localparam int BOFF_W = byte_off_w(DATA_W);
  localparam int WOFF_W = word_off_w(LINE_WORDS);
  localparam int OFF_W  = BOFF_W + WOFF_W;
  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS);
  localparam int LINE_W = DATA_W * LINE_WORDS;

  logic [ADDR_W-1:0] req_addr;
  logic              req_rw;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic [SETS-1:0]   lru;
  logic              victim;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_index;
  logic [WOFF_W-1:0] req_word;

  logic [TAG_W-1:0]  way_tag  [2];
  logic [LINE_W-1:0] way_line [2];
  logic [1:0]        way_valid, way_dirty;
  logic [1:0]        word_we, fill_we, clean_we;

  logic [1:0]        hit_vec;
  logic              hit, hit_way, victim_next;
  logic [LINE_W-1:0] hit_line;
  logic [DATA_W-1:0] old_word, merged_word;
  logic              unused_addr;

  assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
  assign req_index   = req_addr[OFF_W +: IDX_W];
  assign req_word    = req_addr[BOFF_W +: WOFF_W];
  assign unused_addr = &{1'b0, req_addr};

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way_array #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS)
    ) u_way (
      .clock     (clock),
      .reset     (reset),
      .index     (req_index),
      .tag       (way_tag[w]),
      .line      (way_line[w]),
      .valid     (way_valid[w]),
      .dirty     (way_dirty[w]),
      .word_we   (word_we[w]),
      .word_sel  (req_word),
      .word_data (req_wdata),
      .word_be   (req_be),
      .fill_we   (fill_we[w]),
      .fill_tag  (req_tag),
      .fill_line (mem_resp_rdata),
      .clean     (clean_we[w])
    );
  end

  // Both ways matching is illegal, so way1 wins only when it matches.
  always_comb begin
    hit_vec[0]  = way_valid[0] && (way_tag[0] == req_tag);
    hit_vec[1]  = way_valid[1] && (way_tag[1] == req_tag);
    hit         = |hit_vec;
    hit_way     = hit_vec[1];
    hit_line    = hit_way ? way_line[1] : way_line[0];
    old_word    = hit_line[int'(req_word) * DATA_W +: DATA_W];
    merged_word = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (req_be[b]) merged_word[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
    victim_next = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[req_index]);
  end

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      word_we[w]  = (state == LOOKUP) && hit && req_rw && (hit_way == 1'(w));
      fill_we[w]  = (state == FILL_WAIT) && mem_resp_valid && (victim == 1'(w));
      clean_we[w] = (state == WRITE_BACK) && mem_req_ready && (victim == 1'(w));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cache_ready    <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_rw     <= MEM_RD;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      req_addr       <= '0;
      req_rw         <= 1'b0;
      req_wdata      <= '0;
      req_be         <= '0;
      lru            <= '0;
      victim         <= 1'b0;
    end else begin
      cpu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            req_addr    <= cpu_req_addr;
            req_rw      <= cpu_req_rw;
            req_wdata   <= cpu_req_wdata;
            req_be      <= cpu_req_be;
            cache_ready <= 1'b0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            cpu_resp_rdata   <= req_rw ? merged_word : old_word;
            cpu_resp_valid   <= 1'b1;
            lru[req_index]   <= ~hit_way;
            cache_ready      <= 1'b1;
            state            <= IDLE;
          end else begin
            victim        <= victim_next;
            mem_req_valid <= 1'b1;
            if (way_valid[victim_next] && way_dirty[victim_next]) begin
              mem_req_rw    <= MEM_WR;
              mem_req_addr  <= {way_tag[victim_next], req_index, {OFF_W{1'b0}}};
              mem_req_wdata <= way_line[victim_next];
              state         <= WRITE_BACK;
            end else begin
              mem_req_rw   <= MEM_RD;
              mem_req_addr <= {req_tag, req_index, {OFF_W{1'b0}}};
              state        <= FILL_REQ;
            end
          end
        end
        WRITE_BACK: begin
          if (mem_req_ready) begin
            mem_req_rw   <= MEM_RD;
            mem_req_addr <= {req_tag, req_index, {OFF_W{1'b0}}};
            state        <= FILL_REQ;
          end
        end
        FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FILL_WAIT;
          end
        end
        FILL_WAIT: begin
          // The line is written by the way array; the retry in LOOKUP then hits.
          if (mem_resp_valid) state <= LOOKUP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller_2way.sv
// Bench for cache_controller_2way: vector table with CPU and memory scoreboards plus stall/reset sequences.
module tb_cache_controller_2way;
  import cache_pkg::*;

  localparam int LW = 128;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req_valid, cpu_req_rw;
  logic [31:0]   cpu_req_addr, cpu_req_wdata;
  logic [3:0]    cpu_req_be;
  logic          cache_ready, cpu_resp_valid;
  logic [31:0]   cpu_resp_rdata;
  logic          mem_req_valid, mem_req_rw, mem_req_ready, mem_resp_valid;
  logic [31:0]   mem_req_addr;
  logic [LW-1:0] mem_req_wdata, mem_resp_rdata;
  state_t        state;

  always #5 clock = ~clock;

  cache_controller_2way dut (
    .clock(clock), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_be(cpu_req_be),
    .cache_ready(cache_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .state(state)
  );

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_data;
    bit          hit;
    bit          exp_rd;
    bit          exp_wb;
    logic [31:0] wb_addr;
    logic [31:0] wb_word0;
  } vec_t;

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] word0;
  } mem_ev_t;

  int            n_vec = 0;
  int            n_miss = 0;
  logic [31:0]   exp_q[$];
  mem_ev_t       exp_mem_q[$];
  logic [LW-1:0] mem_model [logic [31:0]];

  int            stall_req = 0;
  int            inject_cnt = 0;
  bit            hold_resp = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] get_line(input logic [31:0] a);
    logic [LW-1:0] l;
    if (mem_model.exists(a)) return mem_model[a];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = {a[15:0], 16'(w)};
    return l;
  endfunction

  function automatic vec_t mk(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic [31:0] exp_data, input bit hit,
                              input bit exp_rd, input bit exp_wb, input logic [31:0] wb_addr,
                              input logic [31:0] wb_word0);
    vec_t v;
    v.rw = rw; v.addr = addr; v.wdata = wdata; v.be = be; v.exp_data = exp_data;
    v.hit = hit; v.exp_rd = exp_rd; v.exp_wb = exp_wb; v.wb_addr = wb_addr; v.wb_word0 = wb_word0;
    return v;
  endfunction

  // Memory responder and memory-side scoreboard.
  initial begin
    int            stall_used;
    int            inject_done;
    int            resp_cnt;
    logic [LW-1:0] resp_line;
    mem_ev_t       e;
    stall_used = 0; inject_done = 0; resp_cnt = 0; resp_line = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(negedge clock);
      mem_resp_valid = 1'b0;
      if (inject_cnt != inject_done) begin
        inject_done++;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {4{32'hE0E0_E0E0}};
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = resp_line;
        end
      end
      if (stall_req == 0) stall_used = 0;
      if (mem_req_valid && stall_used < stall_req) begin
        mem_req_ready = 1'b0;
        stall_used++;
      end else begin
        mem_req_ready = 1'b1;
      end
      if (!reset && mem_req_valid && mem_req_ready) begin
        if (exp_mem_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL mem_unexpected: got rw=%0b addr=%0h expected no request", mem_req_rw, mem_req_addr);
        end else begin
          e = exp_mem_q.pop_front();
          check("mem_rw", mem_req_rw, e.rw);
          check("mem_addr", mem_req_addr, e.addr);
          if (e.rw) check("mem_wb_word0", mem_req_wdata[31:0], e.word0);
        end
        if (mem_req_rw) mem_model[mem_req_addr] = mem_req_wdata;
        else if (!hold_resp) begin
          resp_cnt = 3;
          resp_line = get_line(mem_req_addr);
        end
      end
    end
  end

  // CPU-side scoreboard.
  always @(negedge clock) begin
    if (!reset && cpu_resp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL cpu_unexpected: got rdata=%0h expected no response", cpu_resp_rdata);
      end else begin
        check("cpu_rdata", cpu_resp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc;
    if (v.exp_wb) exp_mem_q.push_back('{1'b1, v.wb_addr, v.wb_word0});
    if (v.exp_rd) exp_mem_q.push_back('{1'b0, {v.addr[31:4], 4'h0}, 32'h0});
    exp_q.push_back(v.exp_data);
    cyc = 0;
    @(negedge clock);
    while (!cache_ready && cyc < 200) begin @(negedge clock); cyc++; end
    cpu_req_valid = 1'b1; cpu_req_rw = v.rw; cpu_req_addr = v.addr;
    cpu_req_wdata = v.wdata; cpu_req_be = v.be;
    @(negedge clock);
    cpu_req_valid = 1'b0;
    cyc = 1;
    while (!cpu_resp_valid && cyc < 200) begin @(negedge clock); cyc++; end
    check("resp_seen", cpu_resp_valid, 1'b1);
    if (v.hit) begin
      check("hit_latency", cyc, 2);
      check("ready_with_resp", cache_ready, 1'b1);
    end
    check("mem_events_done", exp_mem_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   waited;
    reset = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0; cpu_req_be = '0;
    mem_model[32'h1000] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};

    tbl.push_back(mk(0, 32'h1004, 0, 4'h0, 32'hBBBB_BBBB, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h1004, 0, 4'h0, 32'hBBBB_BBBB, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1008, 32'h1234_5678, 4'b0011, 32'hCCCC_5678, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h1008, 0, 4'h0, 32'hCCCC_5678, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h2000, 0, 4'h0, 32'h2000_0000, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h1000, 0, 4'h0, 32'hAAAA_AAAA, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h3000, 0, 4'h0, 32'h3000_0000, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h1004, 0, 4'h0, 32'hBBBB_BBBB, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h3004, 0, 4'h0, 32'h3000_0001, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h2000, 0, 4'h0, 32'h2000_0000, 0, 1, 1, 32'h1000, 32'hAAAA_AAAA));
    tbl.push_back(mk(1, 32'h2000, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h1000, 0, 4'h0, 32'hAAAA_AAAA, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h3000, 0, 4'h0, 32'h3000_0000, 0, 1, 1, 32'h2000, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 32'h1008, 0, 4'h0, 32'hCCCC_5678, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h4014, 32'h55AA_AAAA, 4'b1000, 32'h5510_0001, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h4014, 0, 4'h0, 32'h5510_0001, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h5010, 0, 4'h0, 32'h5010_0000, 0, 1, 0, 0, 0));

    repeat (3) @(negedge clock);
    check("rst_cache_ready", cache_ready, 1'b1);
    check("rst_resp_valid", cpu_resp_valid, 1'b0);
    check("rst_resp_rdata", cpu_resp_rdata, 32'h0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_mem_rw", mem_req_rw, 1'b0);
    check("rst_mem_addr", mem_req_addr, 32'h0);
    check("rst_mem_wdata", mem_req_wdata, 128'h0);
    check("rst_state", state, IDLE);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Clean misses in random sets away from sets 0 and 1.
    for (int k = 0; k < 6; k++) begin
      logic [7:0]  set;
      logic [1:0]  w;
      logic [31:0] a;
      set = 8'($urandom_range(2, 255));
      w   = 2'($urandom_range(0, 3));
      a   = {16'h0, 4'(k + 5), set, w, 2'b00};
      run_vec(mk(0, a, 0, 4'h0, {a[15:4], 4'h0, 14'h0, w}, 0, 1, 0, 0, 0));
    end

    // Write-back held off by memory for five cycles.
    stall_req = 5;
    fork
      run_vec(mk(0, 32'h6010, 0, 4'h0, 32'h6010_0000, 0, 1, 1, 32'h4010, 32'h4010_0000));
      begin
        waited = 0;
        @(negedge clock);
        while (!(mem_req_valid && mem_req_rw) && waited < 50) begin @(negedge clock); waited++; end
        check("wb_seen", waited < 50, 1'b1);
        for (int k = 0; k < 5; k++) begin
          check("wb_stall_valid", mem_req_valid, 1'b1);
          check("wb_stall_rw", mem_req_rw, 1'b1);
          check("wb_stall_addr", mem_req_addr, 32'h4010);
          check("wb_stall_word1", mem_req_wdata[63:32], 32'h5510_0001);
          check("wb_stall_ready", cache_ready, 1'b0);
          @(negedge clock);
        end
      end
    join
    stall_req = 0;

    // Reset while waiting for a fill; the late response must be ignored.
    hold_resp = 1'b1;
    exp_mem_q.push_back('{1'b0, 32'hF020, 32'h0});
    @(negedge clock);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'hF024; cpu_req_be = 4'h0;
    @(negedge clock);
    cpu_req_valid = 1'b0;
    waited = 0;
    while (state != FILL_WAIT && waited < 50) begin @(negedge clock); waited++; end
    check("reached_fill_wait", state, FILL_WAIT);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_mem_valid", mem_req_valid, 1'b0);
    check("mid_rst_ready", cache_ready, 1'b1);
    check("mid_rst_mem_addr", mem_req_addr, 32'h0);
    check("mid_rst_state", state, IDLE);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    hold_resp = 1'b0;
    inject_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("stray_resp_state", state, IDLE);
      check("stray_resp_ready", cache_ready, 1'b1);
    end

    run_vec(mk(0, 32'hF024, 0, 4'h0, 32'hF020_0001, 0, 1, 0, 0, 0));
    run_vec(mk(0, 32'h1004, 0, 4'h0, 32'hBBBB_BBBB, 0, 1, 0, 0, 0));
    run_vec(mk(0, 32'h1004, 0, 4'h0, 32'hBBBB_BBBB, 1, 0, 0, 0, 0));

    repeat (3) @(negedge clock);
    check("cpu_q_drained", exp_q.size(), 0);
    check("mem_q_drained", exp_mem_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cache_controller_2way.md
Name: cache_controller_2way

Overview:
Parametrised 2-way set-associative, write-back, write-allocate cache controller; next generation of the single-way controller. It sits between the CPU load/store port and the main-memory line interface.
- Adds per-set LRU replacement.
- Adds byte-enabled word writes, so a write no longer overwrites the whole line.
- Write misses allocate the line before writing.
- Valid bits are cleared on reset.
- Memory-side request and response are separate, so memory may stall.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, CPU word width (multiple of 8)
LINE_WORDS, 4, words per line (power of 2, >=2)
SETS, 256, number of sets (power of 2)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  CPU request present
cpu_req_rw  in  1  1=write, 0=read
cpu_req_addr  in  ADDR_W  byte address
cpu_req_wdata  in  DATA_W  write word
cpu_req_be  in  DATA_W/8  byte enables for writes
cache_ready  out  1  controller can accept a request
cpu_resp_valid  out  1  one-cycle pulse: request complete
cpu_resp_rdata  out  DATA_W  read word, valid with cpu_resp_valid
mem_req_valid  out  1  memory request
mem_req_rw  out  1  1=line write-back, 0=line fill
mem_req_addr  out  ADDR_W  line-aligned address (offset bits 0)
mem_req_wdata  out  DATA_W*LINE_WORDS  write-back line
mem_req_ready  in  1  memory accepts request this cycle
mem_resp_valid  in  1  fill data present (one cycle)
mem_resp_rdata  in  DATA_W*LINE_WORDS  fill line, word 0 in LSBs

Behaviour:
- Address split: byte offset log2(DATA_W/8), word offset log2(LINE_WORDS), index log2(SETS), tag = rest. Defaults: tag [31:12], index [11:4], word [3:2].
- Storage:
  - Per set and way: tag, data line, valid, dirty.
  - Per set: one LRU bit, giving the way to replace next.
  - Valid, dirty and LRU are flops cleared by reset. Tag and data arrays are not reset.
- Reset values: cache_ready=1, cpu_resp_valid=0, cpu_resp_rdata=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_wdata=0, state=IDLE.
- States:
  - IDLE: cache_ready=1. On cpu_req_valid, register addr, rw, wdata and be; drop cache_ready; go to LOOKUP.
  - LOOKUP: hit = valid && tag match in either way (both matching is illegal).
    - Read hit: cpu_resp_rdata = selected word; cpu_resp_valid pulses next cycle; LRU = other way; go to IDLE.
    - Write hit: merge bytes where be=1; set dirty; LRU = other way; respond as for a read hit (rdata = merged word); go to IDLE.
    - Miss: victim = first invalid way (way0 preferred), else the LRU way.
    - Miss with victim valid and dirty: go to WRITE_BACK with mem_req_rw=1, addr = {victim tag, index, 0}, wdata = victim line.
    - Otherwise: go to FILL_REQ with mem_req_rw=0, addr = {req tag, index, 0}.
  - WRITE_BACK: hold mem_req_valid=1 with stable addr, rw and wdata until mem_req_ready. On acceptance, clear the victim's dirty bit and go to FILL_REQ.
  - FILL_REQ: hold a read request until mem_req_ready, then go to FILL_WAIT with mem_req_valid=0.
  - FILL_WAIT: on mem_resp_valid, write the line into the victim way, set tag, valid=1, dirty=0, then go to LOOKUP. The retry hits and completes the request normally, including any write merge.
- Latency:
  - Hit: request accepted in cycle N; cpu_resp_valid in cycle N+2; cache_ready=1 again in N+2.
  - Miss: adds memory latency plus a minimum of 2 cycles.
- cache_ready is 0 in every state except IDLE. cpu_req_valid is ignored while cache_ready=0.
- mem_resp_valid outside FILL_WAIT is ignored.
- Reset at any point (including mid-WRITE_BACK or FILL_WAIT):
  - Immediately returns all outputs to their reset values.
  - All lines become invalid; dirty data is discarded by design.
  - A pending memory response is ignored.

Decomposition:
- Shared package cache_pkg: state enum (IDLE, LOOKUP, WRITE_BACK, FILL_REQ, FILL_WAIT), MEM_RD/MEM_WR constants, and functions deriving the offset, index and tag widths from the parameters.
- One sub-module, cache_way_array, instantiated twice: tag/data storage with valid/dirty flops, a combinational read port, a byte-enabled word write and a full-line fill write.
- FSM, LRU and victim logic stay in the top level.

Test Plan:
1. After reset, read 0x0000_1004: mem_req rd addr 0x0000_1000. Fill line with word1=0xBBBB_BBBB, giving cpu_resp_rdata=0xBBBB_BBBB. Repeat the read: no mem_req, resp exactly 2 cycles after accept.
2. After test 1, write 0x0000_1008, wdata=0x1234_5678, be=4'b0011: no mem traffic. Read 0x0000_1008 returns {old word2[31:16], 16'h5678}.
3. Fill 0x0000_1000 and 0x0000_2000 (both set 0), then read 0x1000, then read 0x3000: fill replaces the 0x2000 way with no write-back. Reads of 0x1000 and 0x3000 then hit, and 0x2000 misses.
4. Write 0x0000_2000 with 0xDEAD_BEEF, be=4'hF, then read 0x1000, then read 0x3000: mem write addr 0x0000_2000 with word0=0xDEAD_BEEF, then mem read 0x0000_3000.
5. Hold mem_req_ready=0 for 5 cycles during WRITE_BACK: mem_req_valid, addr and wdata stay stable, cache_ready=0. Release: exactly one accepted write.
6. Assert reset in FILL_WAIT, then pulse mem_resp_valid after deassert: mem_req_valid=0 immediately, the response is ignored, and a later read of the same address misses.
